// File: rtl/r200_pipe_pkg.sv
// Shared pipeline constants for the r200 core: writeback-select encodings,
// hazard FSM state encoding and the hard-wired zero register index.
// Latency: n/a (constants only). Backpressure: n/a.
package r200_pipe_pkg;

  // ex_wbsel encodings
  localparam logic [1:0] WBSEL_ALU = 2'b00;
  localparam logic [1:0] WBSEL_MEM = 2'b01;
  localparam logic [1:0] WBSEL_PC4 = 2'b10;
  localparam logic [1:0] WBSEL_IMM = 2'b11;

  // x0 never carries a real dependency
  localparam logic [4:0] REG_ZERO = 5'd0;

  // Hazard FSM states; encoding 3 is illegal and recovers to ST_RUN
  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_LU_REPLAY = 2'd1,
    ST_REDIRECT  = 2'd2
  } hz_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments when inc is high and sticks at all-ones.
// Latency: q reflects an increment one clock after inc. Backpressure: none.
// Ports: clk, rst (async, active-high), inc -> q[CNT_W-1:0].
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + ONE;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: load-use stall/replay around ID/EX, wrong-path flush on EX redirect.
// Latency: load-use costs 2 cycles (bubble + replay); a redirect flushes for FLUSH_CYCLES cycles.
// Backpressure: id_stall/if_stall are Mealy in RUN; outputs forced low while rst is high.
// Ports: ID operand info, EX rd/writeback/branch info in; id_stall, if_stall, flush_id,
//        state_o (debug) and two saturating perf counters (stall_cnt, redirect_cnt) out.
module hazard_ctrl
  import r200_pipe_pkg::*;
#(
  parameter logic [1:0] WBSEL_MEM    = r200_pipe_pkg::WBSEL_MEM,
  parameter int         FLUSH_CYCLES = 2,
  parameter int         CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1addr,
  input  logic [4:0]       id_rs2addr,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rdaddr,
  input  logic             ex_regwr,
  input  logic [1:0]       ex_wbsel,
  input  logic             ex_isbr,
  input  logic             ex_brtaken,
  input  logic             ex_willjmp,
  output logic             id_stall,
  output logic             if_stall,
  output logic             flush_id,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] redirect_cnt
);

  // The RUN cycle that sees the redirect already flushes, so the counter
  // only has to cover the remaining FLUSH_CYCLES-1 cycles.
  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  hz_state_t  state, state_nxt;
  logic [2:0] flush_cnt, flush_cnt_nxt;
  logic       lu_hit, redir;
  logic       id_stall_c, if_stall_c, flush_c;

  assign lu_hit = ex_regwr && (ex_wbsel == WBSEL_MEM) && (ex_rdaddr != REG_ZERO) &&
                  ((id_uses_rs1 && (id_rs1addr == ex_rdaddr)) ||
                   (id_uses_rs2 && (id_rs2addr == ex_rdaddr)));
  assign redir  = (ex_isbr && ex_brtaken) || ex_willjmp;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_RUN;
      flush_cnt <= 3'd0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    case (state)
      ST_RUN: begin
        if (redir) begin
          // A single-cycle flush is fully covered by this RUN cycle.
          if (FLUSH_CYCLES > 1) begin
            state_nxt     = ST_REDIRECT;
            flush_cnt_nxt = FLUSH_LOAD;
          end
        end else if (lu_hit) begin
          state_nxt = ST_LU_REPLAY;
        end
      end
      ST_LU_REPLAY: state_nxt = ST_RUN;
      ST_REDIRECT: begin
        // Leave once the decremented count reaches zero.
        if (flush_cnt != 3'd0) flush_cnt_nxt = flush_cnt - 3'd1;
        if (flush_cnt <= 3'd1) state_nxt = ST_RUN;
      end
      default: begin
        state_nxt     = ST_RUN;
        flush_cnt_nxt = 3'd0;
      end
    endcase
  end

  // Output logic
  always_comb begin
    id_stall_c = 1'b0;
    if_stall_c = 1'b0;
    flush_c    = 1'b0;
    case (state)
      ST_RUN: begin
        if (redir) begin
          flush_c = 1'b1;
        end else if (lu_hit) begin
          id_stall_c = 1'b1;
          if_stall_c = 1'b1;
        end
      end
      ST_LU_REPLAY: if_stall_c = 1'b1;
      ST_REDIRECT:  flush_c    = 1'b1;
      default: ;
    endcase
  end

  // Mealy terms would otherwise follow the inputs during reset.
  assign id_stall = id_stall_c && !rst;
  assign if_stall = if_stall_c && !rst;
  assign flush_id = flush_c && !rst;
  assign state_o  = state;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (id_stall || if_stall),
    .q   (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_redirect_cnt (
    .clk (clk),
    .rst (rst),
    .inc ((state == ST_RUN) && redir && !rst),
    .q   (redirect_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (default widths / FLUSH_CYCLES=2, and CNT_W=4 /
// FLUSH_CYCLES=3) share stimulus and are compared every cycle against a cycle-budget model.
// Latency: n/a. Backpressure: n/a.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1addr, id_rs2addr, ex_rdaddr;
  logic       id_uses_rs1, id_uses_rs2, ex_regwr, ex_isbr, ex_brtaken, ex_willjmp;
  logic [1:0] ex_wbsel;

  logic        id_stall_a, if_stall_a, flush_a, id_stall_b, if_stall_b, flush_b;
  logic [1:0]  st_a, st_b;
  logic [15:0] scnt_a, rcnt_a;
  logic [3:0]  scnt_b, rcnt_b;

  always #5 clk = ~clk;

  hazard_ctrl u_dut_a (
    .clk(clk), .rst(rst), .id_rs1addr(id_rs1addr), .id_rs2addr(id_rs2addr),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rdaddr(ex_rdaddr),
    .ex_regwr(ex_regwr), .ex_wbsel(ex_wbsel), .ex_isbr(ex_isbr), .ex_brtaken(ex_brtaken),
    .ex_willjmp(ex_willjmp), .id_stall(id_stall_a), .if_stall(if_stall_a), .flush_id(flush_a),
    .state_o(st_a), .stall_cnt(scnt_a), .redirect_cnt(rcnt_a)
  );

  hazard_ctrl #(.FLUSH_CYCLES(3), .CNT_W(4)) u_dut_b (
    .clk(clk), .rst(rst), .id_rs1addr(id_rs1addr), .id_rs2addr(id_rs2addr),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rdaddr(ex_rdaddr),
    .ex_regwr(ex_regwr), .ex_wbsel(ex_wbsel), .ex_isbr(ex_isbr), .ex_brtaken(ex_brtaken),
    .ex_willjmp(ex_willjmp), .id_stall(id_stall_b), .if_stall(if_stall_b), .flush_id(flush_b),
    .state_o(st_b), .stall_cnt(scnt_b), .redirect_cnt(rcnt_b)
  );

  // Per-instance views so the model loop can index them.
  logic        o_id[2], o_if[2], o_fl[2];
  logic [1:0]  o_st[2];
  logic [15:0] o_scnt[2], o_rcnt[2];
  assign o_id[0] = id_stall_a;  assign o_id[1] = id_stall_b;
  assign o_if[0] = if_stall_a;  assign o_if[1] = if_stall_b;
  assign o_fl[0] = flush_a;     assign o_fl[1] = flush_b;
  assign o_st[0] = st_a;        assign o_st[1] = st_b;
  assign o_scnt[0] = scnt_a;    assign o_scnt[1] = {12'd0, scnt_b};
  assign o_rcnt[0] = rcnt_a;    assign o_rcnt[1] = {12'd0, rcnt_b};

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model: the pipeline is either free, owes one replay cycle, or owes some
  // number of further flush cycles after the redirect cycle itself.
  const int          FL[2] = '{2, 3};
  const int unsigned MX[2] = '{65535, 15};
  bit                m_replay[2];
  int                m_flush[2];
  int unsigned       m_scnt[2], m_rcnt[2];

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      m_replay[i] = 1'b0; m_flush[i] = 0; m_scnt[i] = 0; m_rcnt[i] = 0;
    end
  endtask

  function automatic bit f_lu();
    return ex_regwr && (ex_wbsel == 2'b01) && (ex_rdaddr != 5'd0) &&
           ((id_uses_rs1 && id_rs1addr == ex_rdaddr) || (id_uses_rs2 && id_rs2addr == ex_rdaddr));
  endfunction

  // Inputs are set at posedge+1; compare at posedge+3, then advance the model past the edge.
  task automatic tick();
    bit lu, rd;
    bit e_id[2], e_if[2], e_fl[2];
    int e_st;
    #2;
    lu = f_lu();
    rd = (ex_isbr && ex_brtaken) || ex_willjmp;
    if (rst) model_clear();
    for (int i = 0; i < 2; i++) begin
      e_id[i] = 0; e_if[i] = 0; e_fl[i] = 0;
      e_st = m_replay[i] ? 1 : (m_flush[i] > 0 ? 2 : 0);
      if (!rst) begin
        if (m_replay[i]) e_if[i] = 1;
        else if (m_flush[i] > 0) e_fl[i] = 1;
        else if (rd) e_fl[i] = 1;
        else if (lu) begin e_id[i] = 1; e_if[i] = 1; end
      end
      check($sformatf("id_stall[%0d]", i), 32'(o_id[i]), 32'(e_id[i]));
      check($sformatf("if_stall[%0d]", i), 32'(o_if[i]), 32'(e_if[i]));
      check($sformatf("flush_id[%0d]", i), 32'(o_fl[i]), 32'(e_fl[i]));
      check($sformatf("state[%0d]", i), 32'(o_st[i]), 32'(e_st));
      check($sformatf("stall_cnt[%0d]", i), 32'(o_scnt[i]), m_scnt[i]);
      check($sformatf("redirect_cnt[%0d]", i), 32'(o_rcnt[i]), m_rcnt[i]);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_replay[i] = 0; m_flush[i] = 0; m_scnt[i] = 0; m_rcnt[i] = 0;
      end else begin
        if (m_replay[i]) m_replay[i] = 0;
        else if (m_flush[i] > 0) m_flush[i]--;
        else if (rd) begin
          m_flush[i] = FL[i] - 1;
          if (m_rcnt[i] < MX[i]) m_rcnt[i]++;
        end else if (lu) m_replay[i] = 1;
        if ((e_id[i] || e_if[i]) && m_scnt[i] < MX[i]) m_scnt[i]++;
      end
    end
  endtask

  task automatic idle_inputs();
    id_rs1addr = 0; id_rs2addr = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    ex_rdaddr = 0; ex_regwr = 0; ex_wbsel = 0; ex_isbr = 0; ex_brtaken = 0; ex_willjmp = 0;
  endtask

  // Load to x5 in EX, ID instruction reads x5 through rs1.
  task automatic load_use_x5();
    ex_regwr = 1; ex_wbsel = 2'b01; ex_rdaddr = 5'd5;
    id_uses_rs1 = 1; id_rs1addr = 5'd5;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    model_clear();
    @(posedge clk); #1;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Load-use: stall, replay, free.
    load_use_x5(); tick();
    idle_inputs(); tick(); tick();
    check("t1_stall_cnt", 32'(scnt_a), 32'd2);

    // No hazard through x0 or when rs1 unused.
    load_use_x5(); ex_rdaddr = 0; id_rs1addr = 0; tick(); tick();
    load_use_x5(); id_uses_rs1 = 0; tick(); tick();
    idle_inputs();
    check("t2_stall_cnt", 32'(scnt_a), 32'd2);

    // Taken branch with a concurrent load-use: redirect wins.
    load_use_x5(); ex_isbr = 1; ex_brtaken = 1; tick();
    idle_inputs(); tick(); tick(); tick();
    check("t3_redirect_cnt", 32'(rcnt_a), 32'd1);
    check("t3_state", 32'(st_a), 32'd0);

    // Hazard held across replay, then a redirect arriving during replay.
    load_use_x5(); tick(); tick(); tick(); tick();
    tick(); ex_willjmp = 1; tick();
    idle_inputs(); tick(); tick();

    // Async reset in the middle of a redirect.
    ex_willjmp = 1; tick();
    idle_inputs();
    #1 rst = 1'b1;
    #1;
    check("t5_flush_a", 32'(flush_a), 32'd0);
    check("t5_flush_b", 32'(flush_b), 32'd0);
    check("t5_state_b", 32'(st_b), 32'd0);
    check("t5_rcnt_a", 32'(rcnt_a), 32'd0);
    model_clear();
    tick();
    rst = 1'b0;
    tick();

    // 20 back-to-back load-use pairs saturate the 4-bit counter.
    load_use_x5();
    for (int k = 0; k < 40; k++) tick();
    idle_inputs(); tick();
    check("t6_stall_cnt_sat", 32'(scnt_b), 32'd15);

    // Random traffic with small register ranges so hazards are frequent.
    for (int k = 0; k < 800; k++) begin
      rst         = ($urandom_range(0, 59) == 0);
      id_rs1addr  = 5'($urandom_range(0, 3));
      id_rs2addr  = 5'($urandom_range(0, 3));
      ex_rdaddr   = 5'($urandom_range(0, 3));
      id_uses_rs1 = 1'($urandom);
      id_uses_rs2 = 1'($urandom);
      ex_regwr    = 1'($urandom);
      ex_wbsel    = 2'($urandom);
      ex_isbr     = ($urandom_range(0, 3) == 0);
      ex_brtaken  = 1'($urandom);
      ex_willjmp  = ($urandom_range(0, 9) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
